// File: rtl/gpio_in_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_filter_pkg
// Description : Shared defaults and helpers for the GPIO input filter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_in_filter_pkg;

    // Default number of pad inputs handled by one filter instance.
    localparam int N_PADS_DEF     = 11;
    // Default debounce counter width; stable period is 2**DB_W - 1 ticks.
    localparam int DB_W_DEF       = 4;
    // Default width of the debounce tick prescaler.
    localparam int PRESCALE_W_DEF = 8;

    // Terminal debounce count: reaching it on a tick commits the new level,
    // so a level must disagree for (DB_MAX + 1) consecutive ticks.
    function automatic int db_max(input int db_w);
        return (1 << db_w) - 2;
    endfunction

endpackage : gpio_in_filter_pkg
`default_nettype wire

// File: rtl/gpio_in_filter_chan.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_filter_chan
// Description : One pad channel: 2-flop synchroniser, optional debounce,
//               filtered level and sticky rise/fall edge flags.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_filter_chan
    import gpio_in_filter_pkg::*;
#(
    parameter int DB_W = DB_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic tick,
    input  logic db_en,
    input  logic clr_rise,
    input  logic clr_fall,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [DB_W-1:0] c_db_max  = DB_W'(db_max(DB_W));
    localparam logic [DB_W-1:0] c_cnt_one = DB_W'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_level_d;
    logic            r_rise;
    logic            r_fall;

    // Two-stage synchroniser for the asynchronous pad input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pad;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the synchronised value must disagree with the current level
    // on DB_MAX+1 consecutive ticks before it is committed. With debounce off
    // the counter is parked at zero, so re-enabling starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!db_en) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (tick) begin
            if (r_cnt == c_db_max) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + c_cnt_one;
            end
        end
    end

    // Sticky edge flags, set one cycle after the level moves; a set in the
    // same cycle as a clear pulse wins so no edge is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= (r_level & ~r_level_d) | (r_rise & ~clr_rise);
            r_fall    <= (~r_level & r_level_d) | (r_fall & ~clr_fall);
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule : gpio_in_filter_chan
`default_nettype wire

// File: rtl/gpio_in_filter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_filter
// Description : Pad input conditioning: per-pin synchronise/debounce, edge
//               detection with sticky flags and a masked registered irq.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_filter
    import gpio_in_filter_pkg::*;
#(
    parameter int N_PADS     = N_PADS_DEF,
    parameter int DB_W       = DB_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PADS-1:0]     padin,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic [N_PADS-1:0]     cfg_db_en,
    input  logic [N_PADS-1:0]     cfg_rise_en,
    input  logic [N_PADS-1:0]     cfg_fall_en,
    input  logic [N_PADS-1:0]     clr_rise,
    input  logic [N_PADS-1:0]     clr_fall,
    output logic [N_PADS-1:0]     in_o,
    output logic [N_PADS-1:0]     rise_o,
    output logic [N_PADS-1:0]     fall_o,
    output logic                  irq
);

    localparam logic [PRESCALE_W-1:0] c_presc_one = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] r_presc;
    logic                  w_tick;
    logic                  r_irq;

    // The tick fires while the down-counter sits at zero; coming out of
    // reset that means the very first cycle is a tick.
    assign w_tick = (r_presc == '0);

    // Prescaler down-counter; cfg_prescale is only sampled on reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= cfg_prescale;
        end else begin
            r_presc <= r_presc - c_presc_one;
        end
    end

    generate
        for (genvar gi = 0; gi < N_PADS; gi++) begin : g_chan
            gpio_in_filter_chan #(
                .DB_W     (DB_W)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .pad      (padin[gi]),
                .tick     (w_tick),
                .db_en    (cfg_db_en[gi]),
                .clr_rise (clr_rise[gi]),
                .clr_fall (clr_fall[gi]),
                .level    (in_o[gi]),
                .rise     (rise_o[gi]),
                .fall     (fall_o[gi])
            );
        end
    endgenerate

    // Registered interrupt: any flag whose enable is set; masking only
    // affects irq, the flags themselves are left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((rise_o & cfg_rise_en) | (fall_o & cfg_fall_en));
        end
    end

    assign irq = r_irq;

endmodule : gpio_in_filter
`default_nettype wire
